reg_dump: RTL and testbench

Debug read-out sequencer sitting on a read port of the CPU register file. On a single `start` pulse it walks register indices 0 through `NUM_REGS-1`, reading each through the register file's combinational read port. It presents each {index, value} pair on a valid/ready output stream for a debug/trace sink. It replaces ad-hoc simulation dumps of register contents with a synthesizable, back-pressurable snapshot mechanism.

---
 rtl/reg_dump.sv | 90 +++++++++
 tb/tb_reg_dump.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_dump.sv
// Register-file snapshot sequencer: walks every register index once per start
// pulse and streams {index, value} beats over a valid/ready interface.
module reg_dump #(
    parameter int NUM_REGS = 8,
    parameter int IDX_W    = 3,
    parameter int DATA_W   = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic              reg_write,
    output logic [IDX_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [IDX_W-1:0]  out_index,
    output logic [DATA_W-1:0] out_data,
    output logic              busy,
    output logic              done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [1:0]        state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg, idx_next;
    logic [IDX_W-1:0]  out_index_reg, out_index_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;

    always_comb begin
        state_next     = state_reg;
        idx_next       = idx_reg;
        out_index_next = out_index_reg;
        out_data_next  = out_data_reg;
        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    idx_next   = '0;
                    state_next = S_READ;
                end
            end
            S_READ: begin
                // A write in flight makes this sample stale; retry next cycle
                // so the dump reflects the post-write contents.
                if (!reg_write) begin
                    out_index_next = idx_reg;
                    out_data_next  = rd_data;
                    state_next     = S_SEND;
                end
            end
            S_SEND: begin
                if (out_ready) begin
                    if (idx_reg == LAST_IDX) begin
                        state_next = S_DONE;
                    end else begin
                        idx_next   = idx_reg + IDX_W'(1);
                        state_next = S_READ;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_reg     <= S_IDLE;
            idx_reg       <= '0;
            out_index_reg <= '0;
            out_data_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            out_index_reg <= out_index_next;
            out_data_reg  <= out_data_next;
        end
    end

    assign rd_addr   = idx_reg;
    assign out_valid = (state_reg == S_SEND);
    assign out_index = out_index_reg;
    assign out_data  = out_data_reg;
    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);

endmodule

// File: tb/tb_reg_dump.sv
// Scoreboard bench for reg_dump: directed dumps push expected beats into a queue,
// an independent monitor pops and compares on every accepted beat.
module tb_reg_dump;

    localparam int NUM_REGS = 8;
    localparam int IDX_W    = 3;
    localparam int DATA_W   = 16;

    logic              CLK = 1'b0;
    logic              RST = 1'b1;
    logic              start = 1'b0;
    logic              reg_write = 1'b0;
    logic [IDX_W-1:0]  rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              out_valid;
    logic              out_ready = 1'b1;
    logic [IDX_W-1:0]  out_index;
    logic [DATA_W-1:0] out_data;
    logic              busy;
    logic              done;

    logic [DATA_W-1:0] rf [NUM_REGS];
    assign rd_data = rf[rd_addr];

    reg_dump #(.NUM_REGS(NUM_REGS), .IDX_W(IDX_W), .DATA_W(DATA_W)) dut (
        .CLK(CLK), .RST(RST), .start(start), .reg_write(reg_write),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_index(out_index), .out_data(out_data),
        .busy(busy), .done(done)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [IDX_W+DATA_W-1:0] exp_q [$];
    int acc_cyc [$];
    int done_cyc [$];
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_dump(input int idx3_val);
        for (int i = 0; i < NUM_REGS; i++) begin
            logic [DATA_W-1:0] v;
            v = DATA_W'(16'h0011 * (i + 1));
            if (i == 3 && idx3_val >= 0) v = DATA_W'(idx3_val);
            exp_q.push_back({IDX_W'(i), v});
        end
    endtask

    // Monitor: samples 1 time unit after the falling edge, after drivers settle.
    logic                    hold_pend = 1'b0;
    logic [IDX_W+DATA_W-1:0] held;
    always begin
        @(negedge CLK);
        #1;
        if (!RST) begin
            if (hold_pend) begin
                chk("hold_valid", 32'(out_valid), 32'd1);
                chk("hold_beat", 32'({out_index, out_data}), 32'(held));
            end
            hold_pend = 1'b0;
            if (out_valid) begin
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", 32'({out_index, out_data}), 32'hFFFF_FFFF);
                    end else begin
                        logic [IDX_W+DATA_W-1:0] e;
                        e = exp_q.pop_front();
                        chk("beat", 32'({out_index, out_data}), 32'(e));
                        $display("beat cycle %0d idx %0d data %04h", cyc, out_index, out_data);
                    end
                    acc_cyc.push_back(cyc);
                end else begin
                    hold_pend = 1'b1;
                    held      = {out_index, out_data};
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
        end else begin
            hold_pend = 1'b0;
        end
    end

    task automatic wait_done(input int target, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < 300) begin
            @(negedge CLK);
            n++;
        end
        #2;
        chk(name, 32'(done_cnt >= target), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_busy"}, 32'(busy), 32'd0);
        chk({name, "_done"}, 32'(done), 32'd0);
        chk({name, "_addr"}, 32'(rd_addr), 32'd0);
        chk({name, "_index"}, 32'(out_index), 32'd0);
        chk({name, "_data"}, 32'(out_data), 32'd0);
    endtask

    int t0;
    int busy_cnt;
    int busy_first;
    int d0;

    initial begin
        for (int i = 0; i < NUM_REGS; i++) rf[i] = DATA_W'(16'h0011 * (i + 1));

        // Reset, including a start coincident with reset
        @(negedge CLK); start = 1'b1;
        @(negedge CLK); #1 chk_reset_outputs("rst_hold");
        @(negedge CLK); RST = 1'b0; start = 1'b0;
        #1 chk_reset_outputs("rst_after");

        // Plain dump, out_ready=1: beat timing, done timing, busy window
        push_dump(-1);
        acc_cyc.delete();
        done_cyc.delete();
        @(negedge CLK); start = 1'b1; t0 = cyc;
        busy_cnt = 0; busy_first = -1;
        for (int r = 1; r <= 20; r++) begin
            @(negedge CLK); start = 1'b0;
            #1;
            if (busy) begin
                busy_cnt++;
                if (busy_first < 0) busy_first = r;
            end
        end
        chk("t1_beats", 32'(acc_cyc.size()), 32'd8);
        for (int i = 0; i < acc_cyc.size() && i < 8; i++)
            chk("t1_beat_cycle", 32'(acc_cyc[i] - t0), 32'(2 + 2 * i));
        chk("t1_done_cnt", 32'(done_cyc.size()), 32'd1);
        if (done_cyc.size() > 0) chk("t1_done_cycle", 32'(done_cyc[0] - t0), 32'd17);
        chk("t1_busy_cnt", 32'(busy_cnt), 32'd17);
        chk("t1_busy_first", 32'(busy_first), 32'd1);

        // Back-pressure: out_ready toggles 1-0-0-1
        push_dump(-1);
        d0 = done_cnt;
        @(negedge CLK); start = 1'b1;
        for (int r = 0; r < 200 && done_cnt == d0; r++) begin
            @(negedge CLK); start = 1'b0;
            out_ready = ((r % 4) == 0 || (r % 4) == 3);
        end
        #2;
        chk("t2_done", 32'(done_cnt - d0), 32'd1);
        chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
        @(negedge CLK); out_ready = 1'b1;
        @(negedge CLK);

        // Write to R3 while index 3 is being read
        push_dump(16'h00A5);
        done_cyc.delete();
        d0 = done_cnt;
        @(negedge CLK); start = 1'b1; t0 = cyc;
        @(negedge CLK); start = 1'b0;
        for (int r = 0; r < 50; r++) begin
            #1;
            if (busy && !out_valid && !done && rd_addr == 3'd3) break;
            @(negedge CLK);
        end
        reg_write = 1'b1;
        @(posedge CLK); #1 rf[3] = 16'h00A5;
        @(negedge CLK); reg_write = 1'b0;
        wait_done(d0 + 1, "t3_done_seen");
        if (done_cyc.size() > 0) chk("t3_done_cycle", 32'(done_cyc[0] - t0), 32'd18);
        rf[3] = 16'h0044;
        @(negedge CLK);

        // start pulses during a dump are ignored; start in cycle 18 is accepted
        push_dump(-1);
        push_dump(-1);
        done_cyc.delete();
        d0 = done_cnt;
        @(negedge CLK); start = 1'b1; t0 = cyc;
        for (int r = 1; r <= 19; r++) begin
            @(negedge CLK);
            start = (r == 5 || r == 17 || r == 18);
        end
        start = 1'b0;
        wait_done(d0 + 2, "t4_two_dumps");
        repeat (3) @(negedge CLK);
        #1;
        chk("t4_done_cnt", 32'(done_cnt - d0), 32'd2);
        if (done_cyc.size() >= 2) begin
            chk("t4_done1_cycle", 32'(done_cyc[0] - t0), 32'd17);
            chk("t4_done2_cycle", 32'(done_cyc[1] - t0), 32'd35);
        end
        chk("t4_queue_empty", 32'(exp_q.size()), 32'd0);

        // Reset mid-dump while a beat is stalled in SEND
        d0 = done_cnt;
        @(negedge CLK); start = 1'b1; out_ready = 1'b0; t0 = cyc;
        for (int r = 1; r <= 6; r++) begin
            @(negedge CLK); start = 1'b0;
        end
        @(negedge CLK); RST = 1'b1;
        #1;
        chk("t5_pre_valid", 32'(out_valid), 32'd1);
        chk("t5_pre_index", 32'(out_index), 32'd0);
        @(negedge CLK); RST = 1'b0; out_ready = 1'b1;
        #1 chk_reset_outputs("t5_post");
        repeat (20) @(negedge CLK);
        #1;
        chk("t5_no_done", 32'(done_cnt - d0), 32'd0);
        chk("t5_idle", 32'(busy), 32'd0);
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "timeout");
    end

endmodule
